tx_packet_sequencer: RTL and testbench

- Packet-timing master for the HDMI-over-Ethernet transmit path, in the clk125MHz domain.
- Generates the per-packet byte counter, payload-window strobe, transmission ID and segment number that the TX memory controller and frame builder consume.
- Walks one video frame as an outer loop over transmission IDs (1..redundancy) and an inner loop over segments (0..segment_num_max-1), with a fixed inter-packet gap between packets.
- Terminates each frame and reports completion.

---
 rtl/tx_packet_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_tx_packet_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_packet_sequencer.sv
// Packet-timing master for the HDMI-over-Ethernet TX path (clk125MHz domain).
// Walks one video frame as txid (outer) x segment (inner) packets separated by
// a fixed gap, and drives the byte counter / payload strobe used downstream.
module tx_packet_sequencer #(
    parameter int unsigned SEGMENT_NUMBER_MAX = 150,
    parameter int unsigned PACKET_LEN         = 1490,
    parameter int unsigned DATA_START         = 46,
    parameter int unsigned PAYLOAD_LEN        = 1437,
    parameter int unsigned GAP_LEN            = 16
) (
    input  logic        clk125MHz,
    input  logic        rst,
    input  logic        run,
    input  logic [7:0]  redundancy,
    input  logic [15:0] segment_num_max,
    input  logic        oneframe_done,
    output logic [7:0]  txid,
    output logic [15:0] segment_num,
    output logic [11:0] byte_data_counter,
    output logic        data_user,
    output logic        tx_en,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        busy
);

    if (PACKET_LEN > 4095 || PACKET_LEN == 0) begin : g_packet_len_check
        $error("tx_packet_sequencer: PACKET_LEN must be in 1..4095");
    end
    if (GAP_LEN == 0 || GAP_LEN > 65535) begin : g_gap_len_check
        $error("tx_packet_sequencer: GAP_LEN must be in 1..65535");
    end

    localparam logic [11:0] CNT_LAST  = 12'(PACKET_LEN);
    localparam logic [11:0] DU_FIRST  = 12'(DATA_START);
    localparam logic [11:0] DU_LAST   = 12'(DATA_START + PAYLOAD_LEN - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_LEN - 1);
    localparam logic [15:0] SEG_CLAMP = 16'(SEGMENT_NUMBER_MAX);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_ENDF} state_t;

    state_t      state_q, state_d;
    logic [7:0]  txid_q, txid_d;
    logic [15:0] seg_q, seg_d;
    logic [11:0] cnt_q, cnt_d;
    logic        du_q, du_d;
    logic        txen_q, txen_d;
    logic        fd_q, fd_d;
    logic [15:0] fc_q, fc_d;
    logic        busy_q, busy_d;
    logic [7:0]  red_q, red_d;
    logic [15:0] segl_q, segl_d;
    logic        ofd_q, ofd_d;
    logic [15:0] gap_q, gap_d;

    logic [7:0]  red_cfg;
    logic [15:0] seg_cfg;
    logic        ofd_seen;
    logic        end_of_frame;

    // Sanitise the live configuration inputs (0 -> 1, clamp segment count).
    always_comb begin
        red_cfg = (redundancy == 8'd0) ? 8'd1 : redundancy;
        seg_cfg = segment_num_max;
        if (segment_num_max == 16'd0) begin
            seg_cfg = 16'd1;
        end else if (segment_num_max > SEG_CLAMP) begin
            seg_cfg = SEG_CLAMP;
        end
    end

    // Next-state, index advance and registered-output next values.
    always_comb begin
        state_d = state_q;
        txid_d  = txid_q;
        seg_d   = seg_q;
        cnt_d   = cnt_q;
        fd_d    = 1'b0;
        fc_d    = fc_q;
        red_d   = red_q;
        segl_d  = segl_q;
        ofd_d   = ofd_q;
        gap_d   = gap_q;

        // With redundancy 1 the memory controller decides where the frame ends.
        ofd_seen     = ofd_q | oneframe_done;
        end_of_frame = (red_q == 8'd1) ? ofd_seen
                     : (txid_q == red_q) && (seg_q == segl_q - 16'd1);

        case (state_q)
            S_IDLE: begin
                ofd_d  = 1'b0;
                txid_d = 8'd1;
                seg_d  = '0;
                cnt_d  = '0;
                if (run) begin
                    red_d   = red_cfg;
                    segl_d  = seg_cfg;
                    cnt_d   = 12'd1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                ofd_d = ofd_seen;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    gap_d = '0;
                    ofd_d = 1'b0;
                    if (end_of_frame) begin
                        state_d = S_ENDF;
                        txid_d  = 8'd1;
                        seg_d   = '0;
                    end else begin
                        state_d = S_GAP;
                        if (seg_q < segl_q - 16'd1) begin
                            seg_d = seg_q + 16'd1;
                        end else begin
                            seg_d  = '0;
                            txid_d = txid_q + 8'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 12'd1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_SEND;
                    cnt_d   = 12'd1;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            S_ENDF: begin
                fd_d  = 1'b1;
                fc_d  = fc_q + 16'd1;
                gap_d = '0;
                if (run) begin
                    red_d   = red_cfg;
                    segl_d  = seg_cfg;
                    state_d = S_GAP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes are derived from the next state/counter so they line up
        // with the registered counter value without added latency.
        txen_d = (state_d == S_SEND);
        du_d   = (state_d == S_SEND) && (cnt_d >= DU_FIRST) && (cnt_d <= DU_LAST);
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk125MHz) begin
        if (rst) begin
            state_q <= S_IDLE;
            txid_q  <= 8'd1;
            seg_q   <= '0;
            cnt_q   <= '0;
            du_q    <= 1'b0;
            txen_q  <= 1'b0;
            fd_q    <= 1'b0;
            fc_q    <= '0;
            busy_q  <= 1'b0;
            red_q   <= 8'd1;
            segl_q  <= 16'd1;
            ofd_q   <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            txid_q  <= txid_d;
            seg_q   <= seg_d;
            cnt_q   <= cnt_d;
            du_q    <= du_d;
            txen_q  <= txen_d;
            fd_q    <= fd_d;
            fc_q    <= fc_d;
            busy_q  <= busy_d;
            red_q   <= red_d;
            segl_q  <= segl_d;
            ofd_q   <= ofd_d;
            gap_q   <= gap_d;
        end
    end

    assign txid              = txid_q;
    assign segment_num       = seg_q;
    assign byte_data_counter = cnt_q;
    assign data_user         = du_q;
    assign tx_en             = txen_q;
    assign frame_done        = fd_q;
    assign frame_count       = fc_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_tx_packet_sequencer.sv
// Scoreboard bench for tx_packet_sequencer: expected packets/frames are queued
// when stimulus is applied and checked when the DUT emits them.
module tb_tx_packet_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, run, oneframe_done;
    logic [7:0]  redundancy;
    logic [15:0] segment_num_max;
    logic [7:0]  txid;
    logic [15:0] segment_num;
    logic [11:0] byte_data_counter;
    logic        data_user, tx_en, frame_done, busy;
    logic [15:0] frame_count;

    logic        run_s, ofd_s;
    logic [7:0]  red_s;
    logic [15:0] smax_s;
    logic [7:0]  txid_s;
    logic [15:0] seg_s;
    logic [11:0] cnt_s;
    logic        du_s, en_s, fd_s, busy_s;
    logic [15:0] fc_s;

    tx_packet_sequencer dut (
        .clk125MHz(clk), .rst(rst), .run(run), .redundancy(redundancy),
        .segment_num_max(segment_num_max), .oneframe_done(oneframe_done),
        .txid(txid), .segment_num(segment_num), .byte_data_counter(byte_data_counter),
        .data_user(data_user), .tx_en(tx_en), .frame_done(frame_done),
        .frame_count(frame_count), .busy(busy)
    );

    // Short packets so the 150-segment clamp can be walked in few cycles.
    tx_packet_sequencer #(
        .SEGMENT_NUMBER_MAX(150), .PACKET_LEN(8), .DATA_START(3),
        .PAYLOAD_LEN(4), .GAP_LEN(2)
    ) dut_s (
        .clk125MHz(clk), .rst(rst), .run(run_s), .redundancy(red_s),
        .segment_num_max(smax_s), .oneframe_done(ofd_s),
        .txid(txid_s), .segment_num(seg_s), .byte_data_counter(cnt_s),
        .data_user(du_s), .tx_en(en_s), .frame_done(fd_s),
        .frame_count(fc_s), .busy(busy_s)
    );

    int checks = 0;
    int failures = 0;

    typedef struct { int txid; int seg; int gap; } pkt_t;
    pkt_t pq[$];
    int   fq[$];

    int pkt_starts = 0, frames = 0, starts_s = 0, frames_s = 0;
    bit abort_pkt = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input int t, input int s, input int g);
        pkt_t p;
        p.txid = t; p.seg = s; p.gap = g;
        pq.push_back(p);
    endtask

    function automatic int cur_count(input int which);
        case (which)
            0: return pkt_starts;
            1: return frames;
            2: return starts_s;
            default: return frames_s;
        endcase
    endfunction

    task automatic wait_count(input int which, input int target, input string tag);
        int n = 0;
        while (cur_count(which) < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, cur_count(which) >= target, 1);
    endtask

    // Main DUT monitor: per-packet shape, ids, gaps and frame_done pulses.
    int  cur_len = 0, du_cnt = 0, du_first = 0, du_last = 0;
    int  idle_len = 0, since_end = 0, stray = 0;
    bit  seq_ok = 1'b1, id_ok = 1'b1, prev_en = 1'b0, prev_fd = 1'b0;
    logic [7:0]  st_txid;
    logic [15:0] st_seg;
    always @(negedge clk) begin
        pkt_t e;
        if (tx_en === 1'b1) begin
            if (!prev_en) begin
                pkt_starts++;
                cur_len = 0; du_cnt = 0; du_first = 0; du_last = 0;
                seq_ok = 1'b1; id_ok = 1'b1;
                st_txid = txid; st_seg = segment_num;
                chk("pkt_expected", pq.size() > 0, 1);
                if (pq.size() > 0) begin
                    e = pq.pop_front();
                    chk("pkt_txid", txid, e.txid);
                    chk("pkt_seg", segment_num, e.seg);
                    if (e.gap != 0) chk("gap_len", idle_len, e.gap);
                end
            end
            cur_len++;
            if (byte_data_counter !== cur_len[11:0]) seq_ok = 1'b0;
            if (txid !== st_txid || segment_num !== st_seg) id_ok = 1'b0;
            if (data_user === 1'b1) begin
                du_cnt++;
                if (du_first == 0) du_first = int'(byte_data_counter);
                du_last = int'(byte_data_counter);
            end
            idle_len = 0;
        end else begin
            if (prev_en) begin
                since_end = 1;
                if (abort_pkt) begin
                    abort_pkt = 1'b0;
                end else begin
                    chk("pkt_len", cur_len, 1490);
                    chk("pkt_counter_seq", seq_ok, 1);
                    chk("pkt_ids_stable", id_ok, 1);
                    chk("du_count", du_cnt, 1437);
                    chk("du_first", du_first, 46);
                    chk("du_last", du_last, 1482);
                end
            end else begin
                since_end++;
            end
            idle_len++;
            if (data_user !== 1'b0 || byte_data_counter !== 12'd0) stray++;
        end
        prev_en = (tx_en === 1'b1);
        if (prev_fd) chk("fd_one_cycle", frame_done, 0);
        if (frame_done === 1'b1) begin
            frames++;
            chk("fd_timing", since_end, 2);
            chk("frame_expected", fq.size() > 0, 1);
            if (fq.size() > 0) chk("frame_count", frame_count, fq.pop_front());
        end
        prev_fd = (frame_done === 1'b1);
    end

    // Small DUT monitor: segment sequence must wrap after 149.
    int  exp_seg_s = 0;
    bit  prev_en_s = 1'b0;
    always @(negedge clk) begin
        if (en_s === 1'b1 && !prev_en_s) begin
            starts_s++;
            chk("clamp_seg", seg_s, exp_seg_s);
            exp_seg_s = (exp_seg_s == 149) ? 0 : exp_seg_s + 1;
        end
        prev_en_s = (en_s === 1'b1);
        if (fd_s === 1'b1) frames_s++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; run = 1'b0; oneframe_done = 1'b0;
        redundancy = '0; segment_num_max = '0;
        run_s = 1'b0; ofd_s = 1'b0; red_s = 8'd1; smax_s = 16'd500;
        repeat (3) @(negedge clk);
        chk("rst_txid", txid, 1);
        chk("rst_seg", segment_num, 0);
        chk("rst_cnt", byte_data_counter, 0);
        chk("rst_du", data_user, 0);
        chk("rst_txen", tx_en, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_fc", frame_count, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic frame: redundancy 1, 3 segments, end flagged in the 3rd packet.
        redundancy = 8'd1; segment_num_max = 16'd3;
        push_pkt(1, 0, 0); push_pkt(1, 1, 16); push_pkt(1, 2, 16);
        fq.push_back(1);
        run = 1'b1;
        wait_count(0, 1, "wait_basic_p1");
        chk("busy_in_frame", busy, 1);
        wait_count(0, 3, "wait_basic_p3");
        oneframe_done = 1'b1; run = 1'b0;
        @(negedge clk);
        oneframe_done = 1'b0;
        wait_count(1, 1, "wait_basic_frame");
        repeat (3) @(negedge clk);
        chk("basic_idle_busy", busy, 0);
        chk("basic_idle_txen", tx_en, 0);

        // Redundancy order 3x2; oneframe_done held high must be ignored;
        // mid-frame config change must not alter this frame.
        redundancy = 8'd3; segment_num_max = 16'd2; oneframe_done = 1'b1;
        push_pkt(1, 0, 0);  push_pkt(1, 1, 16); push_pkt(2, 0, 16);
        push_pkt(2, 1, 16); push_pkt(3, 0, 16); push_pkt(3, 1, 16);
        fq.push_back(2);
        run = 1'b1;
        wait_count(0, 4, "wait_red_p1");
        redundancy = 8'd7; segment_num_max = 16'd1;
        wait_count(0, 5, "wait_red_p2");
        run = 1'b0;
        wait_count(1, 2, "wait_red_frame");
        oneframe_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("red_idle_busy", busy, 0);

        // run drop and redundancy change in the 2nd packet of a 3-packet frame.
        redundancy = 8'd3; segment_num_max = 16'd1;
        push_pkt(1, 0, 0); push_pkt(2, 0, 16); push_pkt(3, 0, 16);
        fq.push_back(3);
        run = 1'b1;
        wait_count(0, 11, "wait_drop_p2");
        run = 1'b0; redundancy = 8'd1;
        wait_count(1, 3, "wait_drop_frame");
        repeat (3) @(negedge clk);
        chk("drop_idle_busy", busy, 0);
        chk("drop_idle_txid", txid, 1);
        chk("drop_idle_seg", segment_num, 0);

        // Zero config behaves as 1/1: one packet per frame, back-to-back frames.
        redundancy = 8'd0; segment_num_max = 16'd0; oneframe_done = 1'b1;
        push_pkt(1, 0, 0); push_pkt(1, 0, 17);
        fq.push_back(4); fq.push_back(5);
        run = 1'b1;
        wait_count(0, 14, "wait_zero_p2");
        run = 1'b0;
        wait_count(1, 5, "wait_zero_frames");
        oneframe_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("zero_idle_busy", busy, 0);

        // Reset in the middle of a packet.
        redundancy = 8'd3; segment_num_max = 16'd2;
        push_pkt(1, 0, 0);
        run = 1'b1;
        wait_count(0, 15, "wait_rst_p1");
        begin
            int n = 0;
            while (byte_data_counter !== 12'd700 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            chk("rst_reach_700", byte_data_counter, 700);
        end
        rst = 1'b1; run = 1'b0; abort_pkt = 1'b1;
        @(negedge clk);
        chk("mid_rst_cnt", byte_data_counter, 0);
        chk("mid_rst_txen", tx_en, 0);
        chk("mid_rst_txid", txid, 1);
        chk("mid_rst_seg", segment_num, 0);
        chk("mid_rst_fc", frame_count, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_du", data_user, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_idle_txen", tx_en, 0);

        // Segment clamp on the short-packet instance: 500 -> 150 segments.
        red_s = 8'd1; smax_s = 16'd500; ofd_s = 1'b0;
        run_s = 1'b1;
        wait_count(2, 152, "wait_clamp_pkts");
        ofd_s = 1'b1; run_s = 1'b0;
        wait_count(3, 1, "wait_clamp_frame");
        repeat (3) @(negedge clk);
        chk("clamp_idle_busy", busy_s, 0);
        chk("clamp_frame_count", fc_s, 1);

        chk("queues_drained", pq.size() + fq.size(), 0);
        chk("gap_activity", stray, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
